// File: rtl/seg7_pkg.sv
// Shared character codes and display constants for the seven-segment scan driver.
package seg7_pkg;

    typedef logic [4:0] char_t;

    localparam int NUM_DIGITS = 8;

    localparam char_t CH_0     = 5'h00;
    localparam char_t CH_1     = 5'h01;
    localparam char_t CH_2     = 5'h02;
    localparam char_t CH_3     = 5'h03;
    localparam char_t CH_4     = 5'h04;
    localparam char_t CH_5     = 5'h05;
    localparam char_t CH_6     = 5'h06;
    localparam char_t CH_7     = 5'h07;
    localparam char_t CH_8     = 5'h08;
    localparam char_t CH_9     = 5'h09;
    localparam char_t CH_A     = 5'h0A;
    localparam char_t CH_B     = 5'h0B;
    localparam char_t CH_C     = 5'h0C;
    localparam char_t CH_D     = 5'h0D;
    localparam char_t CH_E     = 5'h0E;
    localparam char_t CH_F     = 5'h0F;
    localparam char_t CH_BLANK = 5'h10;
    localparam char_t CH_G     = 5'h11;
    localparam char_t CH_J     = 5'h12;
    localparam char_t CH_L     = 5'h13;
    localparam char_t CH_P     = 5'h14;
    localparam char_t CH_S     = 5'h15;
    localparam char_t CH_T     = 5'h16;
    localparam char_t CH_U     = 5'h17;
    localparam char_t CH_Y     = 5'h18;
    localparam char_t CH_DASH  = 5'h19;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS*5-1:0] BLANK_FRAME = {NUM_DIGITS{CH_BLANK}};

endpackage

// File: rtl/seg7_glyph_rom.sv
// Character code to active-low {g,f,e,d,c,b,a} segment pattern; purely combinational.
// Unassigned codes render blank.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [4:0] ch,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (ch)
            CH_0:    seg = 7'h40;
            CH_1:    seg = 7'h79;
            CH_2:    seg = 7'h24;
            CH_3:    seg = 7'h30;
            CH_4:    seg = 7'h19;
            CH_5:    seg = 7'h12;
            CH_6:    seg = 7'h02;
            CH_7:    seg = 7'h78;
            CH_8:    seg = 7'h00;
            CH_9:    seg = 7'h10;
            CH_A:    seg = 7'h08;
            CH_B:    seg = 7'h03;
            CH_C:    seg = 7'h46;
            CH_D:    seg = 7'h21;
            CH_E:    seg = 7'h06;
            CH_F:    seg = 7'h0E;
            CH_G:    seg = 7'h42;
            CH_J:    seg = 7'h61;
            CH_L:    seg = 7'h47;
            CH_P:    seg = 7'h0C;
            CH_S:    seg = 7'h12;
            CH_T:    seg = 7'h07;
            CH_U:    seg = 7'h41;
            CH_Y:    seg = 7'h11;
            CH_DASH: seg = 7'h3F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Holds an 8-char frame and scans it onto a common-anode 8-digit display; 1-cycle output latency.
// New frames wait in a one-deep pending buffer and commit only at scan-frame wrap. SEG7_BLINK_EN adds blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_DIV    = 100_000,
    parameter int GUARD_CYCLES = 2_000,
    parameter int BLINK_DIV    = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [39:0] frame_chars,
    input  logic [7:0]  frame_dp,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(DIGIT_DIV);
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIGIT_DIV - 1);
    localparam logic [PW-1:0] GUARD_LVL = PW'(GUARD_CYCLES);

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [39:0]   pend_chars_q, pend_chars_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic          pend_full_q, pend_full_d;
    logic [39:0]   act_chars_q, act_chars_d;
    logic [7:0]    act_dp_q, act_dp_d;
    logic          ready_q, ready_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          boundary;
    logic          xfer;
    logic [5:0]    char_base;
    logic [6:0]    glyph;
    logic          blank_digit;

    assign char_base = {idx_q, 2'b00} + {3'b000, idx_q};

    seg7_glyph_rom u_rom (
        .ch  (act_chars_q[char_base +: 5]),
        .seg (glyph)
    );

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bph_q, bph_d;

    always_comb begin
        bcnt_d = bcnt_q + 1'b1;
        bph_d  = bph_q;
        if (bcnt_q == BLINK_LAST) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bcnt_q <= '0;
            bph_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            bph_q  <= bph_d;
        end
    end

    // Mask is sampled live so the producer can start/stop blinking without sending a frame.
    assign blank_digit = bph_q && blink_mask[idx_q];
`else
    logic blink_unused;
    assign blink_unused = ^blink_mask ^ BLINK_DIV[0];
    assign blank_digit  = 1'b0;
`endif

    assign boundary    = (pre_q == PRE_LAST) && (idx_q == 3'd7);
    assign xfer        = frame_valid && ready_q;
    assign frame_ready = ready_q;

    always_comb begin
        pre_d        = pre_q + 1'b1;
        idx_d        = idx_q;
        pend_chars_d = pend_chars_q;
        pend_dp_d    = pend_dp_q;
        pend_full_d  = pend_full_q;
        act_chars_d  = act_chars_q;
        act_dp_d     = act_dp_q;

        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 3'd1;
        end

        if (xfer) begin
            pend_chars_d = frame_chars;
            pend_dp_d    = frame_dp;
            pend_full_d  = 1'b1;
        end

        // xfer and commit are mutually exclusive: ready is low whenever pending is full.
        if (boundary && pend_full_q) begin
            act_chars_d = pend_chars_q;
            act_dp_d    = pend_dp_q;
            pend_full_d = 1'b0;
        end

        ready_d = !pend_full_d;

        an_d  = (pre_q >= GUARD_LVL) ? ~(8'h01 << (3'd7 - idx_q)) : 8'hFF;
        seg_d = blank_digit ? SEG_OFF : glyph;
        dp_d  = blank_digit ? 1'b1 : ~act_dp_q[idx_q];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_q        <= '0;
            idx_q        <= '0;
            pend_chars_q <= BLANK_FRAME;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            act_chars_q  <= BLANK_FRAME;
            act_dp_q     <= '0;
            ready_q      <= 1'b1;
            an_q         <= 8'hFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            pend_chars_q <= pend_chars_d;
            pend_dp_q    <= pend_dp_d;
            pend_full_q  <= pend_full_d;
            act_chars_q  <= act_chars_d;
            act_dp_q     <= act_dp_d;
            ready_q      <= ready_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: accepted frames are queued and retired at scan wrap; every sampled
// cycle compares an/seg/dp/frame_ready with the expected scan position and displayed frame.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int DD   = 16;
    localparam int GC   = 2;
    localparam int BD   = 64;
    localparam int SCAN = DD * 8;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [39:0] frame_chars = '0;
    logic [7:0]  frame_dp = '0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clock = ~clock;

    seg7_scan_driver #(.DIGIT_DIV(DD), .GUARD_CYCLES(GC), .BLINK_DIV(BD)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_chars (frame_chars),
        .frame_dp    (frame_dp),
        .blink_mask  (blink_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    typedef struct {
        logic [39:0] c;
        logic [7:0]  d;
    } frame_t;

    frame_t      sb_q[$];
    frame_t      mon_f;
    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    int          accepted = 0;
    logic [39:0] cur_c = BLANK_FRAME;
    logic [39:0] out_c = BLANK_FRAME;
    logic [7:0]  cur_d = '0;
    logic [7:0]  out_d = '0;

    // Scoreboard: push on handshake, retire into the displayed frame at each scan wrap.
    always @(posedge clock) begin
        if (!reset) begin
            t = 0;
            sb_q.delete();
            cur_c = BLANK_FRAME;
            cur_d = '0;
            out_c = BLANK_FRAME;
            out_d = '0;
        end else begin
            out_c = cur_c;
            out_d = cur_d;
            if ((t % SCAN) == SCAN - 1 && sb_q.size() > 0) begin
                mon_f = sb_q.pop_front();
                cur_c = mon_f.c;
                cur_d = mon_f.d;
            end
            if (frame_valid && frame_ready) begin
                sb_q.push_back('{frame_chars, frame_dp});
                accepted++;
            end
            t++;
        end
    end

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;  5'h03: return 7'h30;
            5'h04: return 7'h19;  5'h05: return 7'h12;  5'h06: return 7'h02;  5'h07: return 7'h78;
            5'h08: return 7'h00;  5'h09: return 7'h10;  5'h0A: return 7'h08;  5'h0B: return 7'h03;
            5'h0C: return 7'h46;  5'h0D: return 7'h21;  5'h0E: return 7'h06;  5'h0F: return 7'h0E;
            5'h11: return 7'h42;  5'h12: return 7'h61;  5'h13: return 7'h47;  5'h14: return 7'h0C;
            5'h15: return 7'h12;  5'h16: return 7'h07;  5'h17: return 7'h41;  5'h18: return 7'h11;
            5'h19: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {an, seg, dp, frame_ready} for the current sample point.
    function automatic logic [16:0] exp_vec();
        logic [7:0] a;
        logic [6:0] s;
        logic       d;
        int         p, i;
        bit         blank;
        if (t == 0) return {8'hFF, 7'h7F, 1'b1, sb_q.size() == 0};
        p     = (t - 1) % DD;
        i     = ((t - 1) / DD) % 8;
        a     = (p >= GC) ? ~(8'h01 << (7 - i)) : 8'hFF;
        blank = BLINK_ON && ((((t - 1) / BD) % 2) == 1) && blink_mask[i];
        s     = blank ? 7'h7F : glyph(out_c[i*5 +: 5]);
        d     = blank ? 1'b1 : ~out_d[i];
        return {a, s, d, sb_q.size() == 0};
    endfunction

    function automatic logic [39:0] pack8(input logic [4:0] c0, c1, c2, c3, c4, c5, c6, c7);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic wait_pos(input int pos);
        int n = 0;
        while ((t % SCAN) != pos && n < 2 * SCAN) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 2 * SCAN) begin
            errors++;
            $display("FAIL wait_pos timeout: position %0d, wanted %0d", t % SCAN, pos);
        end
    endtask

    task automatic test_reset();
        int guard_cnt = 0;
        int multi_cnt = 0;
        logic [16:0] e;
        reset = 1'b0;
        frame_valid = 1'b0;
        blink_mask = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", frame_ready); end
        reset = 1'b1;
        for (int k = 0; k < SCAN + 20; k++) begin
            @(negedge clock);
            e = exp_vec();
            checks++;
            if ({an, seg, dp, frame_ready} !== e) begin
                errors++;
                $display("FAIL idle_scan t=%0d got %h/%h/%b/%b want %h", t, an, seg, dp, frame_ready, e);
            end
            if (k < SCAN) begin
                if (an == 8'hFF) guard_cnt++;
                else if ($countones(~an) != 1) multi_cnt++;
            end
        end
        checks++;
        if (guard_cnt != 8 * GC) begin errors++; $display("FAIL guard_count got %0d want %0d", guard_cnt, 8 * GC); end
        checks++;
        if (multi_cnt != 0) begin errors++; $display("FAIL one_hot_anode got %0d bad cycles want 0", multi_cnt); end
    endtask

    task automatic test_frame();
        int n = 0;
        logic [16:0] e;
        wait_pos(40);
        frame_chars = pack8(CH_J, CH_1, CH_BLANK, CH_S, CH_E, CH_T, CH_U, CH_P);
        frame_dp    = 8'h00;
        frame_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_valid = 1'b0;
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got %b want 0", frame_ready); end
        for (int k = 0; k < 2 * SCAN; k++) begin
            @(negedge clock);
            e = exp_vec();
            checks++;
            if ({an, seg, dp, frame_ready} !== e) begin
                errors++;
                $display("FAIL frame_scan t=%0d got %h/%h/%b/%b want %h", t, an, seg, dp, frame_ready, e);
            end
        end
        while (an !== 8'h7F && n < SCAN) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (seg !== 7'h61 || dp !== 1'b1) begin
            errors++;
            $display("FAIL leftmost_J got seg=%h dp=%b want seg=61 dp=1", seg, dp);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int acc0;
        logic [16:0] e;
        acc0 = accepted;
        frame_chars = pack8(CH_8, CH_8, CH_8, CH_8, CH_8, CH_8, CH_8, CH_8);
        frame_dp    = 8'hA5;
        frame_valid = 1'b1;
        while (!frame_ready && n < 2 * SCAN) begin @(negedge clock); n++; end
        @(posedge clock);
        @(negedge clock);
        frame_chars = pack8(CH_0, CH_1, CH_2, CH_3, CH_C, CH_D, CH_Y, CH_DASH);
        frame_dp    = 8'h0F;
        n = 0;
        while (n < 2 * SCAN) begin
            e = exp_vec();
            checks++;
            if ({an, seg, dp, frame_ready} !== e) begin
                errors++;
                $display("FAIL b2b_hold t=%0d got %h/%h/%b/%b want %h", t, an, seg, dp, frame_ready, e);
            end
            if (frame_ready) break;
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        @(negedge clock);
        frame_valid = 1'b0;
        checks++;
        if (accepted - acc0 != 2) begin errors++; $display("FAIL b2b_accepts got %0d want 2", accepted - acc0); end
        for (int k = 0; k < 2 * SCAN + 8; k++) begin
            @(negedge clock);
            e = exp_vec();
            checks++;
            if ({an, seg, dp, frame_ready} !== e) begin
                errors++;
                $display("FAIL b2b_scan t=%0d got %h/%h/%b/%b want %h", t, an, seg, dp, frame_ready, e);
            end
        end
        n = 0;
        while (an !== 8'h7F && n < SCAN) begin @(negedge clock); n++; end
        checks++;
        if (seg !== 7'h40 || dp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final got seg=%h dp=%b want seg=40 dp=0", seg, dp);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        wait_pos(1);
        frame_chars = pack8(CH_G, CH_L, CH_A, CH_B, CH_F, CH_9, CH_4, CH_7);
        frame_dp    = 8'hFF;
        frame_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_valid = 1'b0;
        wait_pos(70);
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL pending_before_reset got %b want 0", frame_ready); end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL midreset_an got %h want ff", an); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", frame_ready); end
        checks++; if (seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL midreset_seg got %h/%b want 7f/1", seg, dp); end
        reset = 1'b1;
        for (int k = 0; k < 2 * SCAN + 4; k++) begin
            @(negedge clock);
            e = exp_vec();
            checks++;
            if ({an, seg, dp, frame_ready} !== e) begin
                errors++;
                $display("FAIL after_reset_scan t=%0d got %h/%h/%b/%b want %h", t, an, seg, dp, frame_ready, e);
            end
        end
    endtask

    task automatic test_blink();
        int edge_off = 0;
        int mid_off = 0;
        logic [16:0] e;
        blink_mask  = 8'h81;
        frame_chars = pack8(CH_8, CH_8, CH_8, CH_8, CH_8, CH_8, CH_8, CH_8);
        frame_dp    = 8'h00;
        frame_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_valid = 1'b0;
        wait_pos(2);
        for (int k = 0; k < 3 * SCAN; k++) begin
            @(negedge clock);
            e = exp_vec();
            checks++;
            if ({an, seg, dp, frame_ready} !== e) begin
                errors++;
                $display("FAIL blink_scan t=%0d got %h/%h/%b/%b want %h", t, an, seg, dp, frame_ready, e);
            end
            if (an == 8'hFE || an == 8'h7F) begin
                if (seg != 7'h00) edge_off++;
            end else if (an != 8'hFF && seg != 7'h00) begin
                mid_off++;
            end
        end
        checks++;
        if (mid_off != 0) begin errors++; $display("FAIL blink_steady_mid got %0d dark cycles want 0", mid_off); end
`ifdef SEG7_BLINK_EN
        checks++;
        if (edge_off == 0) begin errors++; $display("FAIL blink_edges got %0d dark cycles want >0", edge_off); end
`else
        checks++;
        if (edge_off != 0) begin errors++; $display("FAIL blink_ignored got %0d dark cycles want 0", edge_off); end
`endif
        blink_mask = '0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_reset_mid();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(200000 * 10);
        errors++;
        $display("FAIL watchdog expired at t=%0d", t);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
